banco_regs_param: RTL and testbench

//  Parametrised register bank for the nRISC datapath: two combinational read ports, one write port.

---
 rtl/banco_regs_param.sv | 153 +++++++++++++++
 tb/tb_banco_regs_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/banco_regs_param.sv
// banco_regs_param: parametrised register bank for the nRISC datapath.
// Two combinational read ports, one write port, an optional hard-wired zero
// register, optional write-to-read forwarding and a sequential bulk-clear
// engine that zeroes one register per clock.
module banco_regs_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] Reg1,
    input  logic [ADDR_W-1:0] Reg2,
    output logic [DATA_W-1:0] Dado1,
    output logic [DATA_W-1:0] Dado2,
    input  logic              EscReg,
    input  logic [ADDR_W-1:0] RegEscr,
    input  logic [DATA_W-1:0] DadoEscr,
    input  logic              LimpaReq,
    output logic              Ocupado,
    output logic              LimpaPronto,
    output logic              EscIgnorado
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                ocupado_q, ocupado_d;
    logic                pronto_q, pronto_d;
    logic                ign_q, ign_d;
    logic                clear_en;
    logic                wr_en;
    logic                fwd_en;
    logic [DEPTH-1:0][DATA_W-1:0] bank_vec;

    // A write lands only when the clear engine is idle; writes to the
    // hard-wired zero register vanish without raising EscIgnorado.
    assign wr_en    = EscReg && !ocupado_q && !((ZERO_REG != 0) && (RegEscr == '0));
    // Forwarding follows the same blocking rule as the write itself.
    assign fwd_en   = (BYPASS != 0) && EscReg && !ocupado_q;
    assign clear_en = (state_q == CLEAR);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
            logic [DATA_W-1:0] reg_q, reg_d;

            // Next value of this entry: clear engine and write port never overlap.
            always_comb begin
                reg_d = reg_q;
                if (clear_en && (ptr_q == IDX)) begin
                    reg_d = '0;
                end else if (wr_en && (RegEscr == IDX)) begin
                    reg_d = DadoEscr;
                end
            end

            // Storage flop for this entry, zeroed by reset.
            always_ff @(posedge clock) begin
                if (!reset) begin
                    reg_q <= '0;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign bank_vec[gi] = reg_q;
        end
    endgenerate

    // Read port 1: zero register first, then forwarding, then stored value.
    always_comb begin
        if ((ZERO_REG != 0) && (Reg1 == '0)) begin
            Dado1 = '0;
        end else if (fwd_en && (RegEscr == Reg1)) begin
            Dado1 = DadoEscr;
        end else begin
            Dado1 = bank_vec[Reg1];
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        if ((ZERO_REG != 0) && (Reg2 == '0)) begin
            Dado2 = '0;
        end else if (fwd_en && (RegEscr == Reg2)) begin
            Dado2 = DadoEscr;
        end else begin
            Dado2 = bank_vec[Reg2];
        end
    end

    // Clear-engine next state and the one-cycle status pulses.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        pronto_d = 1'b0;
        ign_d    = EscReg && ocupado_q;
        case (state_q)
            IDLE: begin
                if (LimpaReq) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                // LimpaReq is deliberately ignored here: no restart, no queueing.
                if (ptr_q == {ADDR_W{1'b1}}) begin
                    state_d  = IDLE;
                    ptr_d    = '0;
                    pronto_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
        ocupado_d = (state_d == CLEAR);
    end

    // Clear-engine state register; reset aborts any clear without a pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
            ign_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            ocupado_q <= ocupado_d;
            pronto_q  <= pronto_d;
            ign_q     <= ign_d;
        end
    end

    assign Ocupado     = ocupado_q;
    assign LimpaPronto = pronto_q;
    assign EscIgnorado = ign_q;

endmodule

// File: tb/tb_banco_regs_param.sv
// Directed testbench for banco_regs_param. Two instances share all inputs:
// u_a uses ZERO_REG=1/BYPASS=1, u_b uses ZERO_REG=0/BYPASS=0.
module tb_banco_regs_param;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] Reg1 = '0, Reg2 = '0, RegEscr = '0;
    logic       EscReg = 1'b0, LimpaReq = 1'b0;
    logic [7:0] DadoEscr = '0;

    logic [7:0] Dado1_a, Dado2_a, Dado1_b, Dado2_b;
    logic       Ocupado_a, LimpaPronto_a, EscIgnorado_a;
    logic       Ocupado_b, LimpaPronto_b, EscIgnorado_b;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    banco_regs_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) u_a (
        .clock(clock), .reset(reset), .Reg1(Reg1), .Reg2(Reg2),
        .Dado1(Dado1_a), .Dado2(Dado2_a), .EscReg(EscReg), .RegEscr(RegEscr),
        .DadoEscr(DadoEscr), .LimpaReq(LimpaReq), .Ocupado(Ocupado_a),
        .LimpaPronto(LimpaPronto_a), .EscIgnorado(EscIgnorado_a)
    );

    banco_regs_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) u_b (
        .clock(clock), .reset(reset), .Reg1(Reg1), .Reg2(Reg2),
        .Dado1(Dado1_b), .Dado2(Dado2_b), .EscReg(EscReg), .RegEscr(RegEscr),
        .DadoEscr(DadoEscr), .LimpaReq(LimpaReq), .Ocupado(Ocupado_b),
        .LimpaPronto(LimpaPronto_b), .EscIgnorado(EscIgnorado_b)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        EscReg   = 1'b1;
        RegEscr  = a;
        DadoEscr = d;
        tick();
        EscReg   = 1'b0;
        $display("wr addr=%0d data=%h", a, d);
    endtask

    task automatic test_reset();
        // Reset must win over a simultaneous write and clear request.
        reset = 1'b0; EscReg = 1'b1; RegEscr = 3'd2; DadoEscr = 8'd77; LimpaReq = 1'b1;
        tick();
        reset = 1'b1; EscReg = 1'b0; LimpaReq = 1'b0;
        #1;
        checks++; if (Ocupado_a !== 1'b0) begin failures++; $display("FAIL reset_ocupado got=%b exp=0", Ocupado_a); end
        checks++; if (LimpaPronto_a !== 1'b0) begin failures++; $display("FAIL reset_pronto got=%b exp=0", LimpaPronto_a); end
        checks++; if (EscIgnorado_a !== 1'b0) begin failures++; $display("FAIL reset_escign got=%b exp=0", EscIgnorado_a); end
        checks++; if (Ocupado_b !== 1'b0) begin failures++; $display("FAIL reset_ocupado_b got=%b exp=0", Ocupado_b); end
        for (int i = 0; i < 8; i++) begin
            Reg1 = 3'(i); Reg2 = 3'(i);
            #1;
            checks++; if (Dado1_a !== 8'h00) begin failures++; $display("FAIL reset_rd_a[%0d] got=%h exp=00", i, Dado1_a); end
            checks++; if (Dado2_b !== 8'h00) begin failures++; $display("FAIL reset_rd_b[%0d] got=%h exp=00", i, Dado2_b); end
        end
        $display("test_reset done");
    endtask

    task automatic test_defaults();
        wr(3'd3, 8'd10);
        wr(3'd6, 8'd5);
        Reg1 = 3'd3; Reg2 = 3'd6;
        #1;
        checks++; if (Dado1_a !== 8'd10) begin failures++; $display("FAIL defaults_d1 got=%0d exp=10", Dado1_a); end
        checks++; if (Dado2_a !== 8'd5) begin failures++; $display("FAIL defaults_d2 got=%0d exp=5", Dado2_a); end
        checks++; if (Dado1_b !== 8'd10) begin failures++; $display("FAIL defaults_d1_b got=%0d exp=10", Dado1_b); end
        checks++; if (Dado2_b !== 8'd5) begin failures++; $display("FAIL defaults_d2_b got=%0d exp=5", Dado2_b); end
    endtask

    task automatic test_zero_reg();
        Reg1 = 3'd0; EscReg = 1'b1; RegEscr = 3'd0; DadoEscr = 8'hFF;
        #1;
        checks++; if (Dado1_a !== 8'h00) begin failures++; $display("FAIL zero_wrcycle got=%h exp=00", Dado1_a); end
        checks++; if (Dado1_b !== 8'h00) begin failures++; $display("FAIL zero_wrcycle_b got=%h exp=00", Dado1_b); end
        tick();
        EscReg = 1'b0;
        $display("wr addr=0 data=ff");
        #1;
        checks++; if (Dado1_a !== 8'h00) begin failures++; $display("FAIL zero_after got=%h exp=00", Dado1_a); end
        checks++; if (Dado1_b !== 8'hFF) begin failures++; $display("FAIL zero_after_b got=%h exp=ff", Dado1_b); end
        checks++; if (EscIgnorado_a !== 1'b0) begin failures++; $display("FAIL zero_escign got=%b exp=0", EscIgnorado_a); end
    endtask

    task automatic test_bypass();
        Reg1 = 3'd3; Reg2 = 3'd4; EscReg = 1'b1; RegEscr = 3'd4; DadoEscr = 8'h5A;
        #1;
        checks++; if (Dado2_a !== 8'h5A) begin failures++; $display("FAIL bypass_fwd got=%h exp=5a", Dado2_a); end
        checks++; if (Dado2_b !== 8'h00) begin failures++; $display("FAIL bypass_off_b got=%h exp=00", Dado2_b); end
        checks++; if (Dado1_a !== 8'd10) begin failures++; $display("FAIL bypass_other got=%h exp=0a", Dado1_a); end
        tick();
        EscReg = 1'b0;
        $display("wr addr=4 data=5a");
        #1;
        checks++; if (Dado2_a !== 8'h5A) begin failures++; $display("FAIL bypass_after got=%h exp=5a", Dado2_a); end
        checks++; if (Dado2_b !== 8'h5A) begin failures++; $display("FAIL bypass_after_b got=%h exp=5a", Dado2_b); end
    endtask

    task automatic test_clear();
        int occ_cnt    = 0;
        int pronto_cnt = 0;
        int pronto_at  = -1;
        for (int i = 1; i < 8; i++) wr(3'(i), 8'(i));
        Reg1 = 3'd7;
        #1;
        checks++; if (Dado1_a !== 8'd7) begin failures++; $display("FAIL clear_prefill got=%h exp=07", Dado1_a); end
        LimpaReq = 1'b1;
        tick();
        LimpaReq = 1'b0;
        Reg1 = 3'd1; Reg2 = 3'd5;
        for (int c = 0; c < 12; c++) begin
            if (Ocupado_a) occ_cnt++;
            if (LimpaPronto_a) begin pronto_cnt++; pronto_at = c; end
            if (c == 2) begin
                checks++; if (Dado1_a !== 8'h00) begin failures++; $display("FAIL clear_mid_done got=%h exp=00", Dado1_a); end
                checks++; if (Dado2_a !== 8'd5) begin failures++; $display("FAIL clear_mid_pend got=%h exp=05", Dado2_a); end
            end
            LimpaReq = (c == 3);
            tick();
        end
        LimpaReq = 1'b0;
        $display("clear occ=%0d pronto=%0d at=%0d", occ_cnt, pronto_cnt, pronto_at);
        checks++; if (occ_cnt !== 8) begin failures++; $display("FAIL clear_busy_cycles got=%0d exp=8", occ_cnt); end
        checks++; if (pronto_cnt !== 1) begin failures++; $display("FAIL clear_pronto_count got=%0d exp=1", pronto_cnt); end
        checks++; if (pronto_at !== 8) begin failures++; $display("FAIL clear_pronto_cycle got=%0d exp=8", pronto_at); end
        for (int i = 0; i < 8; i++) begin
            Reg1 = 3'(i); Reg2 = 3'(i);
            #1;
            checks++; if (Dado1_a !== 8'h00) begin failures++; $display("FAIL clear_rd_a[%0d] got=%h exp=00", i, Dado1_a); end
            checks++; if (Dado2_b !== 8'h00) begin failures++; $display("FAIL clear_rd_b[%0d] got=%h exp=00", i, Dado2_b); end
        end
    endtask

    task automatic test_blocked_write();
        int n = 0;
        wr(3'd5, 8'h11);
        // Write issued in the same cycle as the clear request still lands.
        LimpaReq = 1'b1; EscReg = 1'b1; RegEscr = 3'd2; DadoEscr = 8'h22;
        tick();
        LimpaReq = 1'b0; EscReg = 1'b1; RegEscr = 3'd5; DadoEscr = 8'h33;
        Reg1 = 3'd2; Reg2 = 3'd5;
        #1;
        checks++; if (Ocupado_a !== 1'b1) begin failures++; $display("FAIL blk_busy got=%b exp=1", Ocupado_a); end
        checks++; if (EscIgnorado_a !== 1'b0) begin failures++; $display("FAIL blk_first_escign got=%b exp=0", EscIgnorado_a); end
        checks++; if (Dado1_a !== 8'h22) begin failures++; $display("FAIL blk_req_cycle_wr got=%h exp=22", Dado1_a); end
        checks++; if (Dado2_a !== 8'h11) begin failures++; $display("FAIL blk_no_bypass got=%h exp=11", Dado2_a); end
        tick();
        EscReg = 1'b0;
        $display("wr addr=5 data=33 (during clear)");
        #1;
        checks++; if (EscIgnorado_a !== 1'b1) begin failures++; $display("FAIL blk_escign_pulse got=%b exp=1", EscIgnorado_a); end
        tick();
        checks++; if (EscIgnorado_a !== 1'b0) begin failures++; $display("FAIL blk_escign_clear got=%b exp=0", EscIgnorado_a); end
        while (Ocupado_a && n < 20) begin tick(); n++; end
        checks++; if (Ocupado_a !== 1'b0) begin failures++; $display("FAIL blk_timeout got=%b exp=0", Ocupado_a); end
        checks++; if (LimpaPronto_a !== 1'b1) begin failures++; $display("FAIL blk_pronto got=%b exp=1", LimpaPronto_a); end
        Reg2 = 3'd5;
        #1;
        checks++; if (Dado2_a !== 8'h00) begin failures++; $display("FAIL blk_reg5 got=%h exp=00", Dado2_a); end
        checks++; if (Dado2_b !== 8'h00) begin failures++; $display("FAIL blk_reg5_b got=%h exp=00", Dado2_b); end
    endtask

    task automatic test_reset_mid_clear();
        int bad = 0;
        for (int i = 1; i < 8; i++) wr(3'(i), 8'h40 + 8'(i));
        LimpaReq = 1'b1;
        tick();
        LimpaReq = 1'b0;
        tick(); tick(); tick();
        // ptr is now 3: abort with reset on the next edge.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        checks++; if (Ocupado_a !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", Ocupado_a); end
        checks++; if (LimpaPronto_a !== 1'b0) begin failures++; $display("FAIL rstmid_pronto got=%b exp=0", LimpaPronto_a); end
        for (int i = 0; i < 8; i++) begin
            Reg1 = 3'(i);
            #1;
            checks++; if (Dado1_a !== 8'h00) begin failures++; $display("FAIL rstmid_rd_a[%0d] got=%h exp=00", i, Dado1_a); end
            checks++; if (Dado1_b !== 8'h00) begin failures++; $display("FAIL rstmid_rd_b[%0d] got=%h exp=00", i, Dado1_b); end
        end
        for (int c = 0; c < 10; c++) begin
            if (LimpaPronto_a || Ocupado_a) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL rstmid_quiet got=%0d exp=0", bad); end
        $display("reset mid-clear done");
    endtask

    task automatic test_back_to_back();
        // A fresh clear after the abort must start from ptr 0 and last 8 cycles.
        int occ_cnt = 0;
        LimpaReq = 1'b1;
        tick();
        LimpaReq = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (Ocupado_a) occ_cnt++;
            tick();
        end
        $display("back_to_back occ=%0d", occ_cnt);
        checks++; if (occ_cnt !== 8) begin failures++; $display("FAIL b2b_busy_cycles got=%0d exp=8", occ_cnt); end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_zero_reg();
        test_bypass();
        test_clear();
        test_blocked_write();
        test_reset_mid_clear();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
